fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the RISC-V core; owns the enable and next-value inputs of the PC register.
- Issues one instruction-memory request per PC using a req/ack handshake, with variable memory latency.
- Holds a one-entry output buffer toward decode.
- Applies branch/jump redirects from EX and flushes any wrong-path fetch.

---
 rtl/fetch_ctrl_pkg.sv | 15 +
 rtl/fetch_buf.sv | 61 ++++++
 rtl/fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_fetch_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch definitions: state encoding and PC constants.
// Also imported by the PC register for its reset value.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_FETCH   = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } fstate_t;

  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam int          INST_BYTES = 4;

endpackage

// File: rtl/fetch_buf.sv
// Output register toward decode, plus one skid entry.
// Ports: load/skid_load/promote/consume/flush controls, in_pc/in_inst, valid/pc/inst.
module fetch_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            skid_load,
  input  logic            promote,
  input  logic            consume,
  input  logic            flush,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_inst,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst
);

  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_inst;

  // Flush beats refill, refill beats consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= in_pc;
      inst  <= in_inst;
    end else if (promote && skid_valid) begin
      valid <= 1'b1;
      pc    <= skid_pc;
      inst  <= skid_inst;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_inst  <= '0;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (skid_load) begin
      skid_valid <= 1'b1;
      skid_pc    <= in_pc;
      skid_inst  <= in_inst;
    end else if (promote) begin
      skid_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives the PC register, issues imem req/ack
// fetches, buffers one instruction for decode, applies EX redirects.
module fetch_ctrl #(
  parameter int            XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC =
    XLEN'(fetch_ctrl_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            pc_en,
  output logic [XLEN-1:0] npc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst,
  input  logic            id_ready
);

  import fetch_ctrl_pkg::*;

  fstate_t         state;
  fstate_t         state_nx;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] seq_pc;
  logic            buf_free;
  logic            start_req;
  logic            b_valid;
  logic [XLEN-1:0] b_pc;
  logic [XLEN-1:0] b_inst;
  logic            b_load;
  logic            b_skid;
  logic            b_promote;
  logic            b_flush;

  assign tgt      = {redirect_pc[XLEN-1:2], 2'b00};
  assign seq_pc   = pc + XLEN'(INST_BYTES);
  assign buf_free = !b_valid || id_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_RESET;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_RESET: state_nx = S_FETCH;
      S_FETCH: begin
        unique case (1'b1)
          imem_ack && !redirect_valid && !buf_free:
            state_nx = S_HOLD;
          !imem_ack && redirect_valid:
            state_nx = S_DISCARD;
          default:
            state_nx = S_FETCH;
        endcase
      end
      S_HOLD: begin
        if (redirect_valid || buf_free)
          state_nx = S_FETCH;
      end
      S_DISCARD: begin
        if (imem_ack)
          state_nx = S_FETCH;
      end
      default: state_nx = S_RESET;
    endcase
  end

  always_comb begin
    pc_en    = 1'b0;
    npc      = seq_pc;
    imem_req = 1'b0;
    if (rst) begin
      npc = RESET_PC;
    end else begin
      unique case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          pc_en    = imem_ack || redirect_valid;
          if (redirect_valid) npc = tgt;
        end
        S_HOLD, S_DISCARD: begin
          imem_req = (state == S_DISCARD);
          pc_en    = redirect_valid;
          if (redirect_valid) npc = tgt;
        end
        default: ;
      endcase
    end
  end

  // A new request starts on entry to S_FETCH or after an ack in it;
  // it targets the PC value that will hold after this edge.
  assign start_req = !rst && state_nx == S_FETCH &&
                     (state != S_FETCH || imem_ack);

  always_ff @(posedge clk) begin
    if (rst)            req_addr <= RESET_PC;
    else if (start_req) req_addr <= pc_en ? npc : pc;
  end

  assign imem_addr = req_addr;

  assign b_flush   = !rst && redirect_valid && state != S_RESET;
  assign b_load    = state == S_FETCH && imem_ack &&
                     !redirect_valid && buf_free;
  assign b_skid    = state == S_FETCH && imem_ack &&
                     !redirect_valid && !buf_free;
  assign b_promote = state == S_HOLD && buf_free;

  fetch_buf #(.XLEN(XLEN)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (b_load),
    .skid_load (b_skid),
    .promote   (b_promote),
    .consume   (b_valid && id_ready),
    .flush     (b_flush),
    .in_pc     (req_addr),
    .in_inst   (imem_rdata),
    .valid     (b_valid),
    .pc        (b_pc),
    .inst      (b_inst)
  );

  assign if_valid = b_valid && !rst;
  assign if_pc    = rst ? '0 : b_pc;
  assign if_inst  = rst ? '0 : b_inst;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural PC register.
// Inputs change 1ns after posedge; outputs are checked 2ns after.
module tb_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_en;
  logic [31:0] npc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rst)        pc <= RPC;
    else if (pc_en) pc <= npc;
  end

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pc_en          (pc_en),
    .npc            (npc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .id_ready       (id_ready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; imem_ack = 0; imem_rdata = 0;
    redirect_valid = 0; redirect_pc = 0; id_ready = 1;
    tick();
    tick(); #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_ifv", 32'(if_valid), 0);
    chk("rst_pcen", 32'(pc_en), 0);
    chk("rst_npc", npc, RPC);
    chk("rst_ifpc", if_pc, 0);
    rst = 0; #1;
    chk("sreset_req", 32'(imem_req), 0);

    // zero-wait memory
    tick(); imem_ack = 1; imem_rdata = 32'hA000_0000; #1;
    chk("zw0_req", 32'(imem_req), 1);
    chk("zw0_addr", imem_addr, 32'h0040_0000);
    chk("zw0_pcen", 32'(pc_en), 1);
    chk("zw0_npc", npc, 32'h0040_0004);
    chk("zw0_ifv", 32'(if_valid), 0);
    tick(); imem_rdata = 32'hA000_0001; #1;
    chk("zw1_addr", imem_addr, 32'h0040_0004);
    chk("zw1_ifv", 32'(if_valid), 1);
    chk("zw1_ifpc", if_pc, 32'h0040_0000);
    chk("zw1_inst", if_inst, 32'hA000_0000);
    chk("zw1_pcen", 32'(pc_en), 1);
    tick(); imem_rdata = 32'hA000_0002; #1;
    chk("zw2_addr", imem_addr, 32'h0040_0008);
    chk("zw2_ifpc", if_pc, 32'h0040_0004);
    chk("zw2_inst", if_inst, 32'hA000_0001);

    // 3-cycle latency at 0x0040000C
    tick(); imem_ack = 0; #1;
    chk("lat0_addr", imem_addr, 32'h0040_000C);
    chk("lat0_ifpc", if_pc, 32'h0040_0008);
    chk("lat0_pcen", 32'(pc_en), 0);
    tick(); #1;
    chk("lat1_addr", imem_addr, 32'h0040_000C);
    chk("lat1_ifv", 32'(if_valid), 0);
    chk("lat1_pcen", 32'(pc_en), 0);
    tick(); imem_ack = 1; imem_rdata = 32'hA000_0003; #1;
    chk("lat2_addr", imem_addr, 32'h0040_000C);
    chk("lat2_pcen", 32'(pc_en), 1);
    chk("lat2_npc", npc, 32'h0040_0010);

    // decode stalls with the buffer full -> skid + S_HOLD
    tick(); id_ready = 0; imem_rdata = 32'hA000_0004; #1;
    chk("sk_addr", imem_addr, 32'h0040_0010);
    chk("sk_ifpc", if_pc, 32'h0040_000C);
    chk("sk_pcen", 32'(pc_en), 1);
    tick(); imem_ack = 0; #1;
    chk("hold0_req", 32'(imem_req), 0);
    chk("hold0_ifpc", if_pc, 32'h0040_000C);
    chk("hold0_pcen", 32'(pc_en), 0);
    tick(); #1;
    chk("hold1_req", 32'(imem_req), 0);
    tick(); id_ready = 1; #1;
    chk("hold2_req", 32'(imem_req), 0);
    chk("hold2_ifv", 32'(if_valid), 1);
    chk("hold2_pcen", 32'(pc_en), 0);
    tick(); #1;
    chk("prom_ifpc", if_pc, 32'h0040_0010);
    chk("prom_inst", if_inst, 32'hA000_0004);
    chk("prom_addr", imem_addr, 32'h0040_0014);

    // redirect while 0x00400014 is outstanding
    tick(); redirect_valid = 1; redirect_pc = 32'h0040_0100; #1;
    chk("rd0_addr", imem_addr, 32'h0040_0014);
    chk("rd0_pcen", 32'(pc_en), 1);
    chk("rd0_npc", npc, 32'h0040_0100);
    tick(); redirect_valid = 0; #1;
    chk("rd1_req", 32'(imem_req), 1);
    chk("rd1_addr", imem_addr, 32'h0040_0014);
    chk("rd1_pcen", 32'(pc_en), 0);
    tick(); imem_ack = 1; imem_rdata = 32'hDEAD_0001; #1;
    chk("rd2_addr", imem_addr, 32'h0040_0014);
    tick(); imem_rdata = 32'hA000_0100; #1;
    chk("rd3_addr", imem_addr, 32'h0040_0100);
    chk("rd3_ifv", 32'(if_valid), 0);
    chk("rd3_npc", npc, 32'h0040_0104);
    tick(); imem_ack = 0; #1;
    chk("rd4_ifv", 32'(if_valid), 1);
    chk("rd4_ifpc", if_pc, 32'h0040_0100);
    chk("rd4_inst", if_inst, 32'hA000_0100);

    // redirect coincident with ack, misaligned target
    tick(); imem_ack = 1; imem_rdata = 32'hDEAD_0002;
    redirect_valid = 1; redirect_pc = 32'h0040_0103; #1;
    chk("rc_pcen", 32'(pc_en), 1);
    chk("rc_npc", npc, 32'h0040_0100);
    tick(); imem_ack = 0; redirect_valid = 0; #1;
    chk("rc1_ifv", 32'(if_valid), 0);
    chk("rc1_addr", imem_addr, 32'h0040_0100);

    // reset in the middle of S_DISCARD
    tick(); redirect_valid = 1; redirect_pc = 32'h0040_0200; #1;
    chk("rs0_pcen", 32'(pc_en), 1);
    tick(); redirect_valid = 0; rst = 1; #1;
    chk("rs1_req", 32'(imem_req), 0);
    chk("rs1_npc", npc, RPC);
    chk("rs1_pcen", 32'(pc_en), 0);
    tick(); rst = 0; imem_ack = 1; imem_rdata = 32'hDEAD_0003; #1;
    chk("rs2_req", 32'(imem_req), 0);
    chk("rs2_ifv", 32'(if_valid), 0);
    chk("rs2_pcen", 32'(pc_en), 0);
    tick(); imem_rdata = 32'hA000_0000; #1;
    chk("rs3_addr", imem_addr, RPC);
    chk("rs3_npc", npc, 32'h0040_0004);
    tick(); imem_ack = 0; #1;
    chk("rs4_ifpc", if_pc, RPC);
    chk("rs4_inst", if_inst, 32'hA000_0000);

    // pc+4 wraps at the top of the address space
    tick(); redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; #1;
    chk("wr0_npc", npc, 32'hFFFF_FFFC);
    tick(); redirect_valid = 0; imem_ack = 1; #1;
    chk("wr1_addr", imem_addr, 32'h0040_0004);
    tick(); #1;
    chk("wr2_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wr2_npc", npc, 32'h0000_0000);
    tick(); imem_ack = 0; #1;
    chk("wr3_ifpc", if_pc, 32'hFFFF_FFFC);
    chk("wr3_addr", imem_addr, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
